// File: rtl/uart_bus_scheduler.sv
`timescale 1ns/1ps
// Purpose: arbitrates two TX requesters and one RX consumer onto the single peripheral_uart register bus.
// Latency: grant to first strobe is 1 cycle; each access is HOLD strobe cycles plus one GAP cycle.
// Backpressure: reqN_ready pulses only in IDLE when the byte is taken; accesses are never aborted mid-strobe.
//
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   req0/1_valid, _data, _ready   TX byte handshake (ready is a one-cycle accept pulse)
//   rx_en                         level: keep the receiver armed and collect bytes
//   rx_valid, rx_data             one-cycle pulse with received byte; rx_data holds the last byte
//   sched_busy                    high whenever the scheduler is not idle
//   uart_cs/rd/wr/addr/wdata      peripheral bus strobes, address and write data
//   uart_rdata                    peripheral read data, sampled in the GAP cycle
module uart_bus_scheduler #(
  parameter int HOLD     = 5,
  parameter int POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        rx_en,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        sched_busy,
  output logic        uart_cs,
  output logic        uart_rd,
  output logic        uart_wr,
  output logic [3:0]  uart_addr,
  output logic [15:0] uart_wdata,
  input  logic [15:0] uart_rdata
);

  localparam int CNT_MAX = (HOLD > POLL_GAP) ? HOLD : POLL_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Access phase counter: 0..HOLD-1 strobe, HOLD is the GAP cycle.
  localparam logic [CW-1:0] GAP_IDX   = CW'(HOLD);
  localparam logic [CW-1:0] WAIT_LAST = CW'(POLL_GAP - 1);

  localparam logic [3:0] ADDR_TX_DATA  = 4'h0;
  localparam logic [3:0] ADDR_TX_START = 4'h8;
  localparam logic [3:0] ADDR_STATUS   = 4'hC;
  localparam logic [3:0] ADDR_RX_ARM   = 4'hA;
  localparam logic [3:0] ADDR_RX_DATA  = 4'h2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TX_LOAD  = 4'd1,
    TX_START = 4'd2,
    TX_WAIT  = 4'd3,
    TX_POLL  = 4'd4,
    RX_ARM   = 4'd5,
    RX_WAIT  = 4'd6,
    RX_POLL  = 4'd7,
    RX_READ  = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            last_grant_q, last_grant_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [7:0]      rx_data_q, rx_data_d;

  logic any_req;
  logic grant_sel;
  logic strobe_phase;
  logic gap_phase;
  logic stat_tx_busy;
  logic stat_rx_busy;
  logic unused_rdata_hi;

  assign any_req      = req0_valid | req1_valid;
  // Both valid: the one not granted last wins; otherwise whichever is valid.
  assign grant_sel    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign strobe_phase = (cnt_q < GAP_IDX);
  assign gap_phase    = (cnt_q == GAP_IDX);
  assign stat_tx_busy = uart_rdata[0];
  assign stat_rx_busy = uart_rdata[1];
  assign unused_rdata_hi = ^uart_rdata[15:8];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tx_byte_q    <= 8'h00;
      rx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      last_grant_q <= last_grant_d;
      tx_byte_q    <= tx_byte_d;
      rx_data_q    <= rx_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    last_grant_d = last_grant_q;
    tx_byte_d    = tx_byte_q;
    rx_data_d    = rx_data_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          last_grant_d = grant_sel;
          tx_byte_d    = grant_sel ? req1_data : req0_data;
          state_d      = TX_LOAD;
        end else if (rx_en && !armed_q) begin
          state_d = RX_ARM;
        end else if (armed_q) begin
          state_d = RX_WAIT;
        end
      end

      TX_LOAD, TX_START, TX_POLL, RX_ARM, RX_POLL, RX_READ: begin
        if (!gap_phase) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          case (state_q)
            TX_LOAD:  state_d = TX_START;
            TX_START: state_d = TX_WAIT;
            TX_POLL:  state_d = stat_tx_busy ? TX_WAIT : IDLE;
            RX_ARM: begin
              armed_d = 1'b1;
              state_d = RX_WAIT;
            end
            RX_POLL: begin
              if (!stat_rx_busy) begin
                state_d = RX_READ;
              end else if (any_req) begin
                // TX preempts a pending receive; receiver stays armed.
                state_d = IDLE;
              end else begin
                state_d = RX_WAIT;
              end
            end
            RX_READ: begin
              rx_data_d = uart_rdata[7:0];
              armed_d   = 1'b0;
              state_d   = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      TX_WAIT, RX_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d = '0;
          if (state_q == TX_WAIT) begin
            state_d = TX_POLL;
          end else if (!rx_en) begin
            armed_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RX_POLL;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    uart_cs    = 1'b0;
    uart_rd    = 1'b0;
    uart_wr    = 1'b0;
    uart_addr  = 4'h0;
    uart_wdata = 16'h0000;
    if (strobe_phase) begin
      case (state_q)
        TX_LOAD: begin
          uart_cs    = 1'b1;
          uart_wr    = 1'b1;
          uart_addr  = ADDR_TX_DATA;
          uart_wdata = {8'h00, tx_byte_q};
        end
        TX_START: begin
          uart_cs   = 1'b1;
          uart_wr   = 1'b1;
          uart_addr = ADDR_TX_START;
        end
        TX_POLL, RX_POLL: begin
          uart_cs   = 1'b1;
          uart_rd   = 1'b1;
          uart_addr = ADDR_STATUS;
        end
        RX_ARM: begin
          uart_cs   = 1'b1;
          uart_rd   = 1'b1;
          uart_addr = ADDR_RX_ARM;
        end
        RX_READ: begin
          uart_cs   = 1'b1;
          uart_rd   = 1'b1;
          uart_addr = ADDR_RX_DATA;
        end
        default: ;
      endcase
    end
  end

  // Grants are suppressed while rst is high so no byte is reported accepted during reset.
  assign req0_ready = (state_q == IDLE) && !rst && any_req && !grant_sel;
  assign req1_ready = (state_q == IDLE) && !rst && any_req && grant_sel;
  assign sched_busy = (state_q != IDLE);
  assign rx_valid   = (state_q == RX_READ) && gap_phase;
  // The byte is only sampled at the end of the GAP cycle, so forward it during the pulse.
  assign rx_data    = rx_valid ? uart_rdata[7:0] : rx_data_q;

endmodule

// File: tb/tb_uart_bus_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_bus_scheduler with a small behavioural register model of the UART.
module tb_uart_bus_scheduler;
  localparam int HOLD     = 5;
  localparam int POLL_GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_data, req1_data;
  logic        rx_en, rx_valid, sched_busy;
  logic [7:0]  rx_data;
  logic        uart_cs, uart_rd, uart_wr;
  logic [3:0]  uart_addr;
  logic [15:0] uart_wdata, uart_rdata;

  always #5 clk = ~clk;

  uart_bus_scheduler #(.HOLD(HOLD), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data), .sched_busy(sched_busy),
    .uart_cs(uart_cs), .uart_rd(uart_rd), .uart_wr(uart_wr),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_rdata(uart_rdata)
  );

  // gap = number of cs-low cycles before the access; 8'hFF means don't care.
  typedef struct packed {
    logic [2:0]  typ;
    logic [3:0]  addr;
    logic [15:0] dat;
    logic [7:0]  gap;
  } ev_t;

  localparam logic [2:0] EV_WR = 3'd1, EV_RD = 3'd2, EV_RDY = 3'd3, EV_RXV = 3'd4;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input logic [2:0] t, input logic [3:0] a, input logic [15:0] d,
                             input logic [7:0] g);
    ev_t e;
    e.typ = t; e.addr = a; e.dat = d; e.gap = g;
    return e;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s", what);
  endtask

  task automatic compare_ev(input ev_t obs);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got typ=%0d addr=%h dat=%h gap=%0d, none expected",
               obs.typ, obs.addr, obs.dat, obs.gap);
    end else begin
      e = exp_q.pop_front();
      if (obs.typ !== e.typ || obs.addr !== e.addr || obs.dat !== e.dat ||
          (e.gap != 8'hFF && obs.gap !== e.gap)) begin
        errors++;
        $display("FAIL event: got typ=%0d addr=%h dat=%h gap=%0d expected typ=%0d addr=%h dat=%h gap=%0d",
                 obs.typ, obs.addr, obs.dat, obs.gap, e.typ, e.addr, e.dat, e.gap);
      end
    end
  endtask

  // Full TX transaction: grant, data load, start, then n_busy busy polls and one free poll.
  task automatic exp_tx(input int id, input logic [7:0] b, input logic [7:0] first_gap, input int n_busy);
    exp_q.push_back(mk(EV_RDY, 4'(id), 16'h0000, 8'hFF));
    exp_q.push_back(mk(EV_WR, 4'h0, {8'h00, b}, first_gap));
    exp_q.push_back(mk(EV_WR, 4'h8, 16'h0000, 8'd1));
    for (int i = 0; i <= n_busy; i++) exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000, 8'd17));
  endtask

  // UART register model: status bits count down per status read.
  int         tx_busy_n = 0, rx_busy_n = 0;
  int         tx_left, rx_left;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_armed_m, cs_prev;

  always @(negedge clk) begin
    if (rst) begin
      tx_left = 0; rx_left = 0; rx_armed_m = 1'b0; cs_prev = 1'b0; uart_rdata = 16'h0000;
    end else begin
      if (uart_cs && !cs_prev) begin
        if (uart_wr && uart_addr == 4'h8) tx_left = tx_busy_n;
        if (uart_rd) begin
          case (uart_addr)
            4'hC: begin
              uart_rdata = {14'b0, (rx_armed_m && rx_left > 0), (tx_left > 0)};
              if (tx_left > 0) tx_left = tx_left - 1;
              if (rx_armed_m && rx_left > 0) rx_left = rx_left - 1;
            end
            4'hA: begin rx_armed_m = 1'b1; rx_left = rx_busy_n; uart_rdata = 16'h0000; end
            4'h2: begin uart_rdata = {8'h00, rx_byte}; rx_armed_m = 1'b0; end
            default: uart_rdata = 16'h0000;
          endcase
        end
      end
      cs_prev = uart_cs;
    end
  end

  // Monitor: turns DUT activity into events and checks them against the scoreboard.
  logic        in_stb, stb_rd, stb_wr, stable;
  logic [3:0]  stb_addr;
  logic [15:0] stb_wdata;
  int          len, lowcnt = 255, gap_obs;

  always @(negedge clk) begin
    if (rst) begin
      in_stb = 1'b0;
      lowcnt = 255;
    end else begin
      if (req0_ready || req1_ready) begin
        check_val("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
        if (req0_ready) compare_ev(mk(EV_RDY, 4'h0, 16'h0000, 8'hFF));
        if (req1_ready) compare_ev(mk(EV_RDY, 4'h1, 16'h0000, 8'hFF));
      end
      if (uart_cs) begin
        if (!in_stb) begin
          in_stb = 1'b1; len = 1; gap_obs = lowcnt;
          stb_rd = uart_rd; stb_wr = uart_wr; stb_addr = uart_addr; stb_wdata = uart_wdata;
          stable = uart_rd ^ uart_wr;
        end else begin
          len++;
          if (uart_rd !== stb_rd || uart_wr !== stb_wr || uart_addr !== stb_addr ||
              uart_wdata !== stb_wdata) stable = 1'b0;
        end
      end else begin
        if (in_stb) begin
          in_stb = 1'b0;
          check_val("strobe_len", 32'(len), 32'(HOLD));
          check_val("strobe_stable", 32'(stable), 32'd1);
          compare_ev(mk(stb_wr ? EV_WR : EV_RD, stb_addr, stb_wdata, 8'(gap_obs)));
          lowcnt = 1;
        end else if (lowcnt < 254) begin
          lowcnt++;
        end
      end
      if (rx_valid) compare_ev(mk(EV_RXV, 4'h0, {8'h00, rx_data}, 8'hFF));
    end
  end

  function automatic logic ready_of(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic send(input int id, input logic [7:0] d);
    if (id == 0) begin req0_data = d; req0_valid = 1'b1; end
    else begin req1_data = d; req1_valid = 1'b1; end
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (ready_of(id)) begin
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    timeout_fail("send");
  endtask

  task automatic wait_grants(input int n);
    int got = 0;
    for (int i = 0; i < 5000; i++) begin
      #1;
      if (req0_ready || req1_ready) got++;
      if (got == n) begin
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    timeout_fail("grants");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (!sched_busy) return;
    end
    timeout_fail("idle");
  endtask

  task automatic wait_rx_valid();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (rx_valid) return;
    end
    timeout_fail("rx_valid");
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_strobes"}, 32'({uart_cs, uart_rd, uart_wr}), 32'd0);
    check_val({tag, "_addr_wdata"}, {12'h0, uart_addr, uart_wdata}, 32'd0);
    check_val({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    check_val({tag, "_rx"}, {23'h0, rx_valid, rx_data}, 32'd0);
    check_val({tag, "_busy"}, 32'(sched_busy), 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; rx_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single requester, two busy polls before the UART frees up.
    tx_busy_n = 2;
    exp_tx(0, 8'hEE, 8'hFF, 2);
    send(0, 8'hEE);
    wait_idle();
    repeat (3) @(negedge clk);

    // Both requesters held: last grant was req0, so req1 first, then alternating.
    tx_busy_n = 0;
    exp_tx(1, 8'hC2, 8'hFF, 0);
    exp_tx(0, 8'hEE, 8'd2, 0);
    exp_tx(1, 8'hC2, 8'd2, 0);
    exp_tx(0, 8'hEE, 8'd2, 0);
    req0_data = 8'hEE; req1_data = 8'hC2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grants(4);
    wait_idle();

    // Receive: arm, two busy polls, free poll, read, then re-arm.
    rx_busy_n = 2; rx_byte = 8'hAE;
    exp_q.push_back(mk(EV_RD, 4'hA, 16'h0000, 8'hFF));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000, 8'd17));
    exp_q.push_back(mk(EV_RD, 4'h2, 16'h0000, 8'd1));
    exp_q.push_back(mk(EV_RXV, 4'h0, 16'h00AE, 8'hFF));
    rx_en = 1'b1;
    wait_rx_valid();

    // TX arrives while armed: preempts after one busy poll, then RX resumes without re-arm.
    rx_byte = 8'h3C; rx_busy_n = 4;
    exp_q.push_back(mk(EV_RD, 4'hA, 16'h0000, 8'd2));
    exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000, 8'd17));
    exp_tx(1, 8'hC2, 8'd2, 0);
    exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000, 8'd18));
    exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000, 8'd17));
    exp_q.push_back(mk(EV_RD, 4'hC, 16'h0000, 8'd17));
    exp_q.push_back(mk(EV_RD, 4'h2, 16'h0000, 8'd1));
    exp_q.push_back(mk(EV_RXV, 4'h0, 16'h003C, 8'hFF));
    repeat (10) @(negedge clk);
    send(1, 8'hC2);
    wait_rx_valid();

    // rx_en dropped after the re-arm: no poll, back to IDLE, armed cleared.
    exp_q.push_back(mk(EV_RD, 4'hA, 16'h0000, 8'd2));
    repeat (10) @(negedge clk);
    rx_en = 1'b0;
    wait_idle();
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sched_busy) busy_cycles++;
    end
    check_val("stays_idle", 32'(busy_cycles), 32'd0);
    check_val("rx_data_hold", 32'(rx_data), 32'h3C);

    // Reset in the middle of the 0x8 write, then req0 must win the next contest.
    exp_q.push_back(mk(EV_RDY, 4'h0, 16'h0000, 8'hFF));
    exp_q.push_back(mk(EV_WR, 4'h0, 16'h0011, 8'hFF));
    send(0, 8'h11);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("midreset");
    rst = 1'b0;
    @(negedge clk);
    exp_tx(0, 8'h22, 8'hFF, 0);
    exp_tx(1, 8'h33, 8'd2, 0);
    req0_data = 8'h22; req1_data = 8'h33;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grants(2);
    wait_idle();
    repeat (5) @(negedge clk);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
